// File: rtl/serial_subtractor_3bit.sv
// Bit-serial subtractor: computes A - B - B_in one bit per clock, LSB first,
// through a single full-subtractor cell. Operands are captured on an accepted
// start. Diff/B_out update atomically on the completion edge, which also
// raises a one-cycle done pulse.
module serial_subtractor_3bit #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic [WIDTH-1:0] Diff,
  output logic             B_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             bw_q, bw_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Full-subtractor cell outputs for the current LSB pair.
  logic             sub_bit;
  logic             sub_borrow;

  // Full-subtractor cell: difference bit and borrow for the current bit pair.
  always_comb begin
    sub_bit    = opa_q[0] ^ opb_q[0] ^ bw_q;
    sub_borrow = (~opa_q[0] & opb_q[0]) | (~(opa_q[0] ^ opb_q[0]) & bw_q);
  end

  // Next-state and datapath control; results are only published on completion.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    bw_d    = bw_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // A new operation may be accepted from IDLE or right in the DONE cycle.
          opa_d   = A;
          opb_d   = B;
          bw_d    = B_in;
          cnt_d   = {CW{1'b0}};
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // start is ignored here: nothing is queued.
        opa_d = {1'b0, opa_q[WIDTH-1:1]};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        bw_d  = sub_borrow;
        res_d = {sub_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_BIT) begin
          diff_d  = {sub_bit, res_q[WIDTH-1:1]};
          bout_d  = sub_borrow;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset that aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= {WIDTH{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      bw_q    <= 1'b0;
      res_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      diff_q  <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      bw_q    <= bw_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Diff  = diff_q;
  assign B_out = bout_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
